// File: rtl/mio_pkg.sv
// mio_pkg: shared types and constants for the MIO bus arbiter.
//   state_t  - arbiter FSM states
//   GNT_CPU  - grant encoding for the CPU data port
//   GNT_DBG  - grant encoding for the debug/DMA requester
package mio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   req0  in  CPU request
//   req1  in  debug request
//   last  in  requester granted most recently (GNT_CPU / GNT_DBG)
//   valid out at least one request present
//   gnt   out winner (GNT_CPU / GNT_DBG); meaningful only when valid
module rr_arb2
    import mio_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic gnt
);

    assign valid = req0 | req1;

    // Under contention the side that did not win last time goes next,
    // which gives strict alternation when both keep requesting.
    always_comb begin
        gnt = GNT_CPU;
        if (req0 && req1)
            gnt = (last == GNT_CPU) ? GNT_DBG : GNT_CPU;
        else if (req1)
            gnt = GNT_DBG;
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares one data-memory/MIO port between the CPU data
// port and a debug/DMA requester. One transaction at a time:
// IDLE (arbitrate + latch) -> ACCESS for WAIT_CYCLES cycles -> RESP (ready).
//   clk, reset                  clock, synchronous active-high reset
//   cpu_req/we/addr/wdata       CPU request side
//   cpu_rdata, cpu_ready        CPU read data and one-cycle completion pulse
//   dbg_req/we/addr/wdata       debug request side
//   dbg_rdata, dbg_ready        debug read data and one-cycle completion pulse
//   mem_en/we/addr/wdata        registered memory command
//   mem_rdata                   memory read data, valid in last ACCESS cycle
module mio_bus_arbiter
    import mio_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("mio_bus_arbiter: WAIT_CYCLES must be >= 1");
        end
    endgenerate

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               last_grant;
    logic               gnt_q;

    logic               arb_valid;
    logic               arb_gnt;

    rr_arb2 u_arb (
        .req0  (cpu_req),
        .req1  (dbg_req),
        .last  (last_grant),
        .valid (arb_valid),
        .gnt   (arb_gnt)
    );

    // mem_addr/mem_wdata/mem_we double as the latched copy of the granted
    // request, so they stay stable for the whole ACCESS phase regardless of
    // what the requester does with its inputs afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= GNT_DBG;
            gnt_q      <= GNT_CPU;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            cpu_ready  <= 1'b0;
            dbg_ready  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cpu_ready <= 1'b0;
                    dbg_ready <= 1'b0;
                    if (arb_valid) begin
                        gnt_q      <= arb_gnt;
                        last_grant <= arb_gnt;
                        mem_en     <= 1'b1;
                        mem_we     <= (arb_gnt == GNT_DBG) ? dbg_we    : cpu_we;
                        mem_addr   <= (arb_gnt == GNT_DBG) ? dbg_addr  : cpu_addr;
                        mem_wdata  <= (arb_gnt == GNT_DBG) ? dbg_wdata : cpu_wdata;
                        cnt        <= CNT_W'(WAIT_CYCLES - 1);
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        // Last access cycle: memory data is valid now.
                        if (!mem_we) begin
                            if (gnt_q == GNT_CPU) cpu_rdata <= mem_rdata;
                            else                  dbg_rdata <= mem_rdata;
                        end
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        cpu_ready <= (gnt_q == GNT_CPU);
                        dbg_ready <= (gnt_q == GNT_DBG);
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    cpu_ready <= 1'b0;
                    dbg_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    cpu_ready <= 1'b0;
                    dbg_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb_mio_bus_arbiter: randomized bench for mio_bus_arbiter.
// Two random requesters (index 0 = CPU, 1 = debug) follow the hold-until-ready
// protocol; a transaction-level model predicts, from the grant cycle t0,
// ACCESS in t0+1..t0+W and ready at t0+W+1, with round-robin on contention.
// Memory read data is only meaningful in the last ACCESS cycle; other
// cycles carry random junk so an early or late capture shows up.
module tb_mio_bus_arbiter;

    localparam int W    = 2;
    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        cpu_ready, dbg_ready;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mio_bus_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_ready (dbg_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // requester stimulus
    bit          pend[2];
    bit          rq_we[2];
    logic [31:0] rq_addr[2];
    logic [31:0] rq_wdata[2];

    // transaction model
    bit          busy;
    int          t0, g, last, ph, req_pct;
    bit          l_we, after_rst, exp_en;
    logic [31:0] l_addr, l_wdata, rd_drv;
    logic [31:0] exp_rd[2];
    logic [31:0] mem_m[16];

    task automatic drive_reqs();
        cpu_req   = pend[0];
        cpu_we    = rq_we[0];
        cpu_addr  = rq_addr[0];
        cpu_wdata = rq_wdata[0];
        dbg_req   = pend[1];
        dbg_we    = rq_we[1];
        dbg_addr  = rq_addr[1];
        dbg_wdata = rq_wdata[1];
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = $urandom();
        for (int r = 0; r < 2; r++) begin
            pend[r] = 0; rq_we[r] = 0; rq_addr[r] = '0; rq_wdata[r] = '0; exp_rd[r] = '0;
        end
        busy = 0; last = 1; after_rst = 1; t0 = 0; g = 0;
        l_we = 0; l_addr = '0; l_wdata = '0;
        reset = 1'b1;
        mem_rdata = '0;
        drive_reqs();
        repeat (3) @(posedge clk);

        for (cyc = 1; cyc <= NCYC; cyc++) begin
            @(posedge clk);
            #1;
            ph = busy ? cyc - t0 : -1;
            case ((cyc / 400) % 3)
                0:       req_pct = 90;
                1:       req_pct = 40;
                default: req_pct = 10;
            endcase

            for (int r = 0; r < 2; r++) begin
                if (!pend[r]) begin
                    if ($urandom_range(99) < req_pct) begin
                        pend[r]     = 1;
                        rq_we[r]    = ($urandom_range(1) == 1);
                        rq_addr[r]  = $urandom() & 32'h0000_00FC;
                        rq_wdata[r] = $urandom();
                    end
                end else if (busy && g == r && ph >= 1 && ph <= W && $urandom_range(3) == 0) begin
                    // granted request already latched: changes must be ignored
                    rq_we[r]    = ~rq_we[r];
                    rq_addr[r]  = $urandom();
                    rq_wdata[r] = $urandom();
                end
            end
            drive_reqs();
            reset = ($urandom_range(59) == 0);

            if (busy && ph == W && !l_we) rd_drv = mem_m[l_addr[5:2]];
            else                          rd_drv = $urandom();
            mem_rdata = rd_drv;

            @(negedge clk);
            exp_en = busy && ph >= 1 && ph <= W;
            chk("mem_en", {63'd0, mem_en}, {63'd0, exp_en});
            chk("mem_we", {63'd0, mem_we}, {63'd0, exp_en && l_we});
            if (exp_en) begin
                chk("mem_addr",  {32'd0, mem_addr},  {32'd0, l_addr});
                chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, l_wdata});
            end else if (after_rst) begin
                chk("rst_mem_addr",  {32'd0, mem_addr},  64'd0);
                chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
            end
            chk("cpu_ready", {63'd0, cpu_ready}, {63'd0, busy && ph == W + 1 && g == 0});
            chk("dbg_ready", {63'd0, dbg_ready}, {63'd0, busy && ph == W + 1 && g == 1});
            chk("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, exp_rd[0]});
            chk("dbg_rdata", {32'd0, dbg_rdata}, {32'd0, exp_rd[1]});

            after_rst = reset;
            if (reset) begin
                // aborted transaction is dropped; requesters start over
                busy = 0; last = 1;
                exp_rd[0] = '0; exp_rd[1] = '0;
                pend[0] = 0; pend[1] = 0;
            end else if (busy) begin
                if (ph == 1 && l_we)   mem_m[l_addr[5:2]] = l_wdata;
                if (ph == W && !l_we)  exp_rd[g] = rd_drv;
                if (ph == W + 1) begin
                    busy    = 0;
                    pend[g] = 0;
                end
            end else if (pend[0] || pend[1]) begin
                if (pend[0] && pend[1]) g = 1 - last;
                else                    g = pend[1] ? 1 : 0;
                last    = g;
                busy    = 1;
                t0      = cyc;
                l_we    = rq_we[g];
                l_addr  = rq_addr[g];
                l_wdata = rq_wdata[g];
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
